seg_display_scheduler: RTL
==========================

Name: seg_display_scheduler

Overview:
Time-multiplexing scheduler for the 4-digit common-anode 7-segment display that shows the 16-bit AES result.
- Accepts a new 16-bit value over a valid/ready handshake.
- Applies it only at frame boundaries, so the display never tears.
- Sequences digits with a programmable on-time and an all-off ghosting gap between digits.
- Drives active-low anodes and the 4-bit nibble consumed by the hex-to-segment decoder.

Parameters:
ON_CYCLES, 100000, clocks each digit's anode is held active (>=1)
GAP_CYCLES, 1000, clocks all anodes are off between digits (0 = no gap state)
CNT_W, 17, phase counter width; must hold max(ON_CYCLES, GAP_CYCLES)-1

Ports:
clkin  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
enable  in  1  1 = scan display; 0 = blank, stay in IDLE
load_valid  in  1  load_data valid
load_data  in  16  value to display; digit0 = [3:0] ... digit3 = [15:12]
load_ready  out  1  can accept a load; equals ~pend_full
anode  out  4  active-low one-hot digit enable; bit n = digit n
nibble  out  4  hex value of the active digit; 0 when no digit is active
digit_sel  out  2  index of the current/last digit slot
frame_tick  out  1  one-cycle pulse at end of each frame

Behaviour:
- All outputs are registered except load_ready.
- Reset values: state=IDLE, anode=4'b1111, nibble=0, digit_sel=0, frame_tick=0, shadow=0, pend_full=0 (load_ready=1), counter=0.
- Handshake:
  - A load is accepted when load_valid & load_ready at a clock edge; it writes the pend register and sets pend_full.
  - load_data may change freely when not accepted.
- Pend to shadow transfer happens, and pend_full clears, in either case:
  - at a frame boundary;
  - on any cycle where state=IDLE and pend_full=1. The transfer takes one cycle, so load_ready returns high the cycle after.
- Since load_ready is low while pend_full=1, an accept and a transfer never collide.
- FSM states: IDLE, ON, GAP.
  - IDLE: anode=1111, nibble=0, counter=0, digit_sel=0. If enable=1, go to ON (digit 0) on the next edge.
  - ON: anode drives ~(1<<digit_sel); nibble = shadow[4*digit_sel +: 4].
    - Stays ON_CYCLES clocks, counter 0..ON_CYCLES-1.
    - Then goes to GAP, or directly to the next digit's ON if GAP_CYCLES=0.
  - GAP: anode=1111, nibble=0; stays GAP_CYCLES clocks, then advances digit_sel.
- digit_sel wraps 3 -> 0.
- The frame boundary is the transition out of digit 3's last slot (its GAP, or its ON if GAP_CYCLES=0).
  - frame_tick pulses on the cycle after that edge.
  - The shadow update is visible in the first ON cycle of digit 0.
- Frame length = 4*(ON_CYCLES+GAP_CYCLES) clocks.
- Disable: enable=0 in ON/GAP moves to IDLE on the next edge.
  - anode=1111 and digit_sel=0 in that same cycle; counter cleared.
  - No frame_tick is generated.
  - A pending value transfers while in IDLE.
- Reset mid-frame returns all state to reset values on the next edge. Pending data and shadow are lost.
- Counter arithmetic is unsigned, CNT_W bits, with no wrap beyond terminal count. Terminal compare uses PARAM-1 truncated to CNT_W.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: during a digit-n ON slot, anode is forced to 1111 and nibble to 0 if shadow[15:4*n]==0 and n!=0. Digit 0 always shows, so value 0 displays a single "0". Slot timing and frame length are unchanged.
- Undefined: all four digits are always driven, with leading zeros shown.

Decomposition:
- Package seg_disp_pkg holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_ON=2'd1, ST_GAP=2'd2;
  - constants NUM_DIGITS=4, DIGIT_W=4, ANODE_OFF=4'b1111.
- One natural sub-module: seg_phase_counter. It is a loadable terminal-count counter with clear, and outputs a done flag for ON/GAP duration. The FSM and handshake stay in the top.

Test Plan:
Tests use ON_CYCLES=4, GAP_CYCLES=2 (24-clock frame).
1. Reset, enable=1, load 16'h1A2F.
   - anode sequence 1110(x4), 1111(x2), 1101(x4), 1111(x2), 1011, 0111, each with its gap.
   - nibbles F,2,A,1.
   - frame_tick every 24 clocks.
2. Load 16'h1234 mid-frame while showing 16'hABCD.
   - load_ready drops to 0; display stays ABCD until the frame ends.
   - First digit-0 ON slot of the next frame shows nibble 4.
   - load_ready returns to 1 one cycle after the frame boundary.
3. Hold load_valid with load_ready=0.
   - Second value is not accepted until ready=1; exactly one accept per ready window.
4. enable=0 during digit 2 ON.
   - Next cycle: anode=1111, digit_sel=0, no frame_tick.
   - Re-enable: digit 0 ON restarts with a full 4-cycle slot.
5. GAP_CYCLES=0, ON_CYCLES=1.
   - anode rotates 1110, 1101, 1011, 0111 each clock.
   - frame_tick every 4 clocks.
6. With LEAD_ZERO_BLANK_EN defined, load 16'h0005.
   - Only digit 0 is lit, nibble 5; digits 1-3 slots give anode=1111.
   - Load 16'h0000: digit 0 shows 0.

Source files
------------

// File: rtl/seg_display_scheduler_pkg.sv
// seg_disp_pkg: shared constants, state encoding and digit helpers for the
// 7-segment display scheduler.
//   ST_IDLE/ST_ON/ST_GAP : FSM state encodings
//   NUM_DIGITS, DIGIT_W  : display geometry
//   ANODE_OFF            : active-low "all digits dark" pattern
package seg_disp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int         NUM_DIGITS = 4;
    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ON   = ST_ON,
        S_GAP  = ST_GAP
    } state_t;

    // Hex nibble shown in digit slot idx.
    function automatic logic [DIGIT_W-1:0] digit_of(input logic [15:0] v,
                                                    input logic [1:0]  idx);
        return v[DIGIT_W*idx +: DIGIT_W];
    endfunction

    // Active-low one-hot anode for digit idx.
    function automatic logic [3:0] anode_of(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // True when every digit from idx upward is zero.
    function automatic logic upper_zero(input logic [15:0] v,
                                        input logic [1:0]  idx);
        return (v >> (DIGIT_W*idx)) == 16'd0;
    endfunction

endpackage

// File: rtl/seg_display_scheduler_phase_counter.sv
// seg_phase_counter: slot duration counter for the display scheduler.
// Counts 0..term, returns to 0 after term, holds 0 while clr is set.
//   clkin  : clock
//   reset  : synchronous active-high reset
//   clr    : synchronous clear (dominates en)
//   en     : advance the count
//   term   : terminal count for the current slot (duration-1)
//   count  : current count
//   done   : count has reached term; the slot ends on this edge
module seg_phase_counter #(
    parameter int CNT_W = 17
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    assign done = (count == term);

    always_ff @(posedge clkin) begin
        if (reset || clr)
            count <= '0;
        else if (en)
            count <= done ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: time-multiplexes a 16-bit value onto a 4-digit
// common-anode 7-segment display. New values arrive over valid/ready into a
// pend register and are copied to the displayed shadow only at a frame
// boundary (or while idle), so a frame never mixes two values.
//   clkin, reset          : clock, synchronous active-high reset
//   enable                : 1 = scan, 0 = blank and idle
//   load_valid/load_data  : offered value (digit0 = [3:0])
//   load_ready            : pend register is empty
//   anode                 : active-low one-hot digit enable
//   nibble                : hex value for the segment decoder, 0 when dark
//   digit_sel             : current/last digit slot
//   frame_tick            : one-cycle pulse after each frame boundary
// Optional build macro LEAD_ZERO_BLANK_EN: blank leading zero digits
// (digit 0 always shows).
module seg_display_scheduler
    import seg_disp_pkg::*;
#(
    parameter int ON_CYCLES  = 100000,
    parameter int GAP_CYCLES = 1000,
    parameter int CNT_W      = 17
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  anode,
    output logic [3:0]  nibble,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam logic [CNT_W-1:0] ON_T  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_T = CNT_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       LAST  = 2'(NUM_DIGITS - 1);

    state_t      state, st_nx;
    logic [1:0]  dsel_nx;
    logic [15:0] pend, shadow, shadow_nx;
    logic        pend_full;
    logic        boundary, xfer, accept, blank, lit;
    logic [CNT_W-1:0] count, term;
    logic        done;

    assign load_ready = ~pend_full;
    assign accept     = load_valid & load_ready;
    assign term       = (state == S_GAP) ? GAP_T : ON_T;

    seg_phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clkin (clkin),
        .reset (reset),
        .clr   (st_nx == S_IDLE),
        .en    (state != S_IDLE),
        .term  (term),
        .count (count),
        .done  (done)
    );

    always_comb begin
        st_nx    = state;
        dsel_nx  = digit_sel;
        boundary = 1'b0;
        case (state)
            S_IDLE: begin
                dsel_nx = 2'd0;
                if (enable) st_nx = S_ON;
            end
            S_ON: begin
                if (!enable) begin
                    st_nx   = S_IDLE;
                    dsel_nx = 2'd0;
                end else if (done) begin
                    if (GAP_CYCLES == 0) begin
                        dsel_nx  = digit_sel + 2'd1;
                        boundary = (digit_sel == LAST);
                    end else begin
                        st_nx = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (!enable) begin
                    st_nx   = S_IDLE;
                    dsel_nx = 2'd0;
                end else if (done) begin
                    st_nx    = S_ON;
                    dsel_nx  = digit_sel + 2'd1;
                    boundary = (digit_sel == LAST);
                end
            end
            default: begin
                st_nx   = S_IDLE;
                dsel_nx = 2'd0;
            end
        endcase

        xfer      = pend_full && (boundary || state == S_IDLE);
        // Outputs are built from the next shadow so a transfer is visible
        // in the very first ON cycle of digit 0.
        shadow_nx = xfer ? pend : shadow;
`ifdef LEAD_ZERO_BLANK_EN
        blank = (dsel_nx != 2'd0) && upper_zero(shadow_nx, dsel_nx);
`else
        blank = 1'b0;
`endif
        lit = (st_nx == S_ON) && !blank;
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state      <= S_IDLE;
            anode      <= ANODE_OFF;
            nibble     <= 4'd0;
            digit_sel  <= 2'd0;
            frame_tick <= 1'b0;
            shadow     <= 16'd0;
            pend       <= 16'd0;
            pend_full  <= 1'b0;
        end else begin
            state      <= st_nx;
            digit_sel  <= dsel_nx;
            frame_tick <= boundary;
            shadow     <= shadow_nx;
            anode      <= lit ? anode_of(dsel_nx) : ANODE_OFF;
            nibble     <= lit ? digit_of(shadow_nx, dsel_nx) : 4'd0;
            // accept and xfer are mutually exclusive (ready low while full)
            if (accept) begin
                pend      <= load_data;
                pend_full <= 1'b1;
            end else if (xfer) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule
